// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizing for the regfile_sync slice.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int REGFILE_NUM_REG = 8;
  localparam int REGFILE_DATA_W  = 16;

endpackage

// File: rtl/regfile_sync_if.sv
// regfile_sync_if: decode/ALU-facing bus of the register file.
// master = decode/ALU side driving indices, write data and flag updates;
// slave  = the register file returning operands, flags and status.
interface regfile_sync_if
  import regfile_pkg::*;
#(
  parameter int  NUM_REG = REGFILE_NUM_REG,
  parameter int  DATA_W  = REGFILE_DATA_W,
  localparam int ADDR_W  = $clog2(NUM_REG)
);

  logic [ADDR_W-1:0] source_reg1_pi;
  logic [ADDR_W-1:0] source_reg2_pi;
  logic              wr_en_pi;
  logic [ADDR_W-1:0] wr_reg_pi;
  logic [DATA_W-1:0] wr_data_pi;
  logic              carry_we_pi;
  logic              new_carry_pi;
  logic              borrow_we_pi;
  logic              new_borrow_pi;
  logic [DATA_W-1:0] reg1_data_po;
  logic [DATA_W-1:0] reg2_data_po;
  logic              current_carry_po;
  logic              current_borrow_po;
  logic              ready_po;
  logic              wr_dropped_po;

  modport master (
    output source_reg1_pi, source_reg2_pi,
    output wr_en_pi, wr_reg_pi, wr_data_pi,
    output carry_we_pi, new_carry_pi, borrow_we_pi, new_borrow_pi,
    input  reg1_data_po, reg2_data_po,
    input  current_carry_po, current_borrow_po,
    input  ready_po, wr_dropped_po
  );

  modport slave (
    input  source_reg1_pi, source_reg2_pi,
    input  wr_en_pi, wr_reg_pi, wr_data_pi,
    input  carry_we_pi, new_carry_pi, borrow_we_pi, new_borrow_pi,
    output reg1_data_po, reg2_data_po,
    output current_carry_po, current_borrow_po,
    output ready_po, wr_dropped_po
  );

endinterface

// File: rtl/regfile_init_fsm.sv
// regfile_init_fsm: post-reset sequencer that walks every register index once,
// asking the top level to write the init value, then parks in RUN and raises ready.
// RUN is left only through reset.
module regfile_init_fsm
  import regfile_pkg::*;
#(
  parameter int  NUM_REG = REGFILE_NUM_REG,
  localparam int ADDR_W  = $clog2(NUM_REG)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REG - 1);

  state_e            r_state;
  state_e            w_stateNext;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idxNext;
  logic              r_ready;
  logic              w_readyNext;

  // State, index and ready registers; reset restarts the clear from index 0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= INIT;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_ready <= w_readyNext;
    end
  end

  // One init write per clock; the write to the last index also hands over to RUN
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_readyNext = r_ready;
    o_init_we   = 1'b0;
    o_init_addr = r_idx;
    case (r_state)
      INIT: begin
        o_init_we = i_rst_n;
        if (r_idx == LAST_IDX) begin
          w_stateNext = RUN;
          w_readyNext = 1'b1;
        end else begin
          w_idxNext = r_idx + 1'b1;
        end
      end
      RUN: begin
        w_stateNext = RUN;
        w_readyNext = 1'b1;
      end
      default: begin
        w_stateNext = INIT;
        w_idxNext   = '0;
        w_readyNext = 1'b0;
      end
    endcase
  end

  assign o_ready = r_ready;

endmodule

// File: rtl/regfile_sync.sv
// regfile_sync: architectural register file with two combinational read ports,
// one synchronous write port, writable carry/borrow flags and a post-reset
// hardware clear. Optional macro REGFILE_BYPASS_EN forwards same-cycle legal
// writes (data and flags) straight to the read outputs.
module regfile_sync
  import regfile_pkg::*;
#(
  parameter int                NUM_REG    = REGFILE_NUM_REG,
  parameter int                DATA_W     = REGFILE_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter bit                ZERO_REG0  = 1'b0,
  localparam int               ADDR_W     = $clog2(NUM_REG)
) (
  input  logic          clk_pi,
  input  logic          rst_n_pi,
  regfile_sync_if.slave bus
);

  logic [DATA_W-1:0] r_regs [NUM_REG];
  logic              r_carry;
  logic              r_borrow;
  logic              r_wrDropped;

  logic              w_ready;
  logic              w_initWe;
  logic [ADDR_W-1:0] w_initAddr;
  logic              w_wrLegal;
  logic              w_userWe;
  logic              w_dropNext;
  logic              w_arrayWe;
  logic [ADDR_W-1:0] w_arrayAddr;
  logic [DATA_W-1:0] w_arrayData;

  regfile_init_fsm #(
    .NUM_REG(NUM_REG)
  ) u_initFsm (
    .i_clk      (clk_pi),
    .i_rst_n    (rst_n_pi),
    .o_init_we  (w_initWe),
    .o_init_addr(w_initAddr),
    .o_ready    (w_ready)
  );

  // Qualify the user write: out-of-range or hard-zero targets are discarded
  always_comb begin
    w_wrLegal  = (int'(bus.wr_reg_pi) < NUM_REG) &&
                 !(ZERO_REG0 && (bus.wr_reg_pi == '0));
    w_userWe   = rst_n_pi && w_ready && bus.wr_en_pi && w_wrLegal;
    w_dropNext = rst_n_pi && bus.wr_en_pi && !(w_ready && w_wrLegal);
  end

  // Single array write port shared by the init sequencer and the user
  always_comb begin
    w_arrayWe   = w_initWe || w_userWe;
    w_arrayAddr = bus.wr_reg_pi;
    w_arrayData = bus.wr_data_pi;
    if (w_initWe) begin
      w_arrayAddr = w_initAddr;
      w_arrayData = INIT_VALUE;
    end
  end

  // Register storage has no reset; the init sequencer clears it instead
  always_ff @(posedge clk_pi) begin
    if (w_arrayWe) begin
      r_regs[w_arrayAddr] <= w_arrayData;
    end
  end

  // Flags clear on reset and accept independent updates only once running
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else if (w_ready) begin
      if (bus.carry_we_pi) begin
        r_carry <= bus.new_carry_pi;
      end
      if (bus.borrow_we_pi) begin
        r_borrow <= bus.new_borrow_pi;
      end
    end
  end

  // One-cycle pulse for any write request that was thrown away
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      r_wrDropped <= 1'b0;
    end else begin
      r_wrDropped <= w_dropNext;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] value;
    value = '0;
    if (w_ready && (int'(idx) < NUM_REG) && !(ZERO_REG0 && (idx == '0))) begin
      value = r_regs[idx];
`ifdef REGFILE_BYPASS_EN
      if (w_userWe && (idx == bus.wr_reg_pi)) begin
        value = bus.wr_data_pi;
      end
`endif
    end
    return value;
  endfunction

  // Combinational operand and flag outputs, all forced to 0 until the clear is done
  always_comb begin
    bus.reg1_data_po      = readPort(bus.source_reg1_pi);
    bus.reg2_data_po      = readPort(bus.source_reg2_pi);
    bus.current_carry_po  = w_ready && r_carry;
    bus.current_borrow_po = w_ready && r_borrow;
`ifdef REGFILE_BYPASS_EN
    if (w_ready && bus.carry_we_pi) begin
      bus.current_carry_po = bus.new_carry_pi;
    end
    if (w_ready && bus.borrow_we_pi) begin
      bus.current_borrow_po = bus.new_borrow_pi;
    end
`endif
    bus.ready_po      = w_ready;
    bus.wr_dropped_po = r_wrDropped;
  end

endmodule

// File: tb/tb_regfile_sync.sv
// tb_regfile_sync: self-checking bench for regfile_sync.
// Instance A uses default parameters and is checked with a table, hand-written
// sequences and randomized traffic against an edge-counting reference model.
// Instance B (NUM_REG=6, ZERO_REG0=1, non-zero INIT_VALUE) covers dropped writes.
module tb_regfile_sync;
  import regfile_pkg::*;

  localparam int          NUM_A  = 8;
  localparam int          NUM_B  = 6;
  localparam int          DW     = 16;
  localparam logic [15:0] INIT_B = 16'h5A5A;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   checks = 0;
  int   errors = 0;

  regfile_sync_if #(.NUM_REG(NUM_A), .DATA_W(DW)) busA ();
  regfile_sync_if #(.NUM_REG(NUM_B), .DATA_W(DW)) busB ();

  regfile_sync #(
    .NUM_REG(NUM_A), .DATA_W(DW), .INIT_VALUE(16'h0000), .ZERO_REG0(1'b0)
  ) dutA (
    .clk_pi(clk), .rst_n_pi(rstA), .bus(busA)
  );

  regfile_sync #(
    .NUM_REG(NUM_B), .DATA_W(DW), .INIT_VALUE(INIT_B), .ZERO_REG0(1'b1)
  ) dutB (
    .clk_pi(clk), .rst_n_pi(rstB), .bus(busB)
  );

  always #5 clk = ~clk;

  // Reference model for instance A: counts init edges, holds architectural contents
  logic [DW-1:0] mRegs [NUM_A];
  logic          mCarry     = 1'b0;
  logic          mBorrow    = 1'b0;
  logic          mDropped   = 1'b0;
  int            mInitEdges = 0;

  function automatic bit mReady();
    return mInitEdges >= NUM_A;
  endfunction

  function automatic void modelEdge();
    if (!rstA) begin
      mInitEdges = 0;
      mCarry     = 1'b0;
      mBorrow    = 1'b0;
      mDropped   = 1'b0;
    end else if (!mReady()) begin
      mDropped = busA.wr_en_pi;
      mInitEdges++;
      if (mReady()) begin
        foreach (mRegs[i]) mRegs[i] = 16'h0000;
      end
    end else begin
      mDropped = busA.wr_en_pi && (int'(busA.wr_reg_pi) >= NUM_A);
      if (busA.wr_en_pi && (int'(busA.wr_reg_pi) < NUM_A)) mRegs[busA.wr_reg_pi] = busA.wr_data_pi;
      if (busA.carry_we_pi)  mCarry  = busA.new_carry_pi;
      if (busA.borrow_we_pi) mBorrow = busA.new_borrow_pi;
    end
  endfunction

  function automatic logic [DW-1:0] expRead(input logic [2:0] idx);
    if (!mReady() || int'(idx) >= NUM_A) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (rstA && busA.wr_en_pi && idx == busA.wr_reg_pi) return busA.wr_data_pi;
`endif
    return mRegs[idx];
  endfunction

  function automatic logic expFlag(input logic stored, input logic we, input logic newVal);
    if (!mReady()) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we) return newVal;
`endif
    return stored;
  endfunction

  typedef struct {
    logic        wrEn;
    logic [2:0]  wrReg;
    logic [15:0] wrData;
    logic        cwe;
    logic        nc;
    logic        bwe;
    logic        nb;
    logic [2:0]  s1;
    logic [2:0]  s2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eC;
    logic        eB;
    logic        eD;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    busA.wr_en_pi       = v.wrEn;
    busA.wr_reg_pi      = v.wrReg;
    busA.wr_data_pi     = v.wrData;
    busA.carry_we_pi    = v.cwe;
    busA.new_carry_pi   = v.nc;
    busA.borrow_we_pi   = v.bwe;
    busA.new_borrow_pi  = v.nb;
    busA.source_reg1_pi = v.s1;
    busA.source_reg2_pi = v.s2;
    #1;
  endtask

  task automatic idleA();
    busA.wr_en_pi     = 1'b0;
    busA.carry_we_pi  = 1'b0;
    busA.borrow_we_pi = 1'b0;
  endtask

  initial begin
    rstA = 1'b0;
    rstB = 1'b0;
    busA.source_reg1_pi = '0; busA.source_reg2_pi = '0; busA.wr_reg_pi = '0;
    busA.wr_data_pi = '0; busA.new_carry_pi = 1'b0; busA.new_borrow_pi = 1'b0;
    idleA();
    busB.source_reg1_pi = '0; busB.source_reg2_pi = '0; busB.wr_en_pi = 1'b0;
    busB.wr_reg_pi = '0; busB.wr_data_pi = '0; busB.carry_we_pi = 1'b0;
    busB.new_carry_pi = 1'b0; busB.borrow_we_pi = 1'b0; busB.new_borrow_pi = 1'b0;

    //             wrEn  reg   data      cwe   nc    bwe   nb    s1    s2    e1        e2        eC    eB    eD
    vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 3'd2, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 3'd7, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 3'd0, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 16'h0F0F, 16'hBEEF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 3'd3, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd7, 16'h0001, 16'h1234, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};

    // Reset held for three edges
    repeat (3) tick();
    checkOutput("reset ready", busA.ready_po, 0);
    checkOutput("reset dropped", busA.wr_dropped_po, 0);
    checkOutput("reset carry", busA.current_carry_po, 0);
    checkOutput("reset borrow", busA.current_borrow_po, 0);

    // Init: write attempted on the second init edge, ready after exactly 8 edges
    rstA = 1'b1;
    busA.wr_reg_pi = 3'd2; busA.wr_data_pi = 16'hFFFF; busA.source_reg1_pi = 3'd2;
    for (int e = 1; e <= NUM_A; e++) begin
      busA.wr_en_pi = (e == 2);
      tick();
      busA.wr_en_pi = 1'b0;
      #1;
      checkOutput($sformatf("init ready e%0d", e), busA.ready_po, (e == NUM_A));
      checkOutput($sformatf("init dropped e%0d", e), busA.wr_dropped_po, (e == 2));
      checkOutput($sformatf("init read R2 e%0d", e), busA.reg1_data_po, 0);
    end
    for (int i = 0; i < NUM_A; i++) begin
      busA.source_reg1_pi = 3'(i);
      busA.source_reg2_pi = 3'(NUM_A - 1 - i);
      #1;
      checkOutput($sformatf("cleared p1 R%0d", i), busA.reg1_data_po, 0);
      checkOutput($sformatf("cleared p2 R%0d", NUM_A - 1 - i), busA.reg2_data_po, 0);
    end
    checkOutput("cleared carry", busA.current_carry_po, 0);
    checkOutput("cleared borrow", busA.current_borrow_po, 0);

    // Table-driven RUN vectors, observed after the write edge with enables dropped
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v]);
      tick();
      idleA();
      #1;
      checkOutput($sformatf("vec%0d reg1", v), busA.reg1_data_po, vecs[v].e1);
      checkOutput($sformatf("vec%0d reg2", v), busA.reg2_data_po, vecs[v].e2);
      checkOutput($sformatf("vec%0d carry", v), busA.current_carry_po, vecs[v].eC);
      checkOutput($sformatf("vec%0d borrow", v), busA.current_borrow_po, vecs[v].eB);
      checkOutput($sformatf("vec%0d dropped", v), busA.wr_dropped_po, vecs[v].eD);
    end

    // Read-during-write on R5
    busA.source_reg1_pi = 3'd5; busA.source_reg2_pi = 3'd3;
    busA.wr_reg_pi = 3'd5; busA.wr_data_pi = 16'h00AA; busA.wr_en_pi = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("rdw R5 same cycle", busA.reg1_data_po, 16'h00AA);
`else
    checkOutput("rdw R5 same cycle", busA.reg1_data_po, 16'h0000);
`endif
    checkOutput("rdw other port", busA.reg2_data_po, 16'h0001);
    tick();
    idleA();
    #1;
    checkOutput("rdw R5 next cycle", busA.reg1_data_po, 16'h00AA);

    // Reset mid-RUN: ready drops next cycle, init reruns and clears the array
    rstA = 1'b0;
    tick();
    checkOutput("midrun reset ready", busA.ready_po, 0);
    checkOutput("midrun reset read", busA.reg1_data_po, 0);
    checkOutput("midrun reset carry", busA.current_carry_po, 0);
    rstA = 1'b1;
    for (int e = 1; e <= NUM_A; e++) begin
      tick();
      checkOutput($sformatf("reinit ready e%0d", e), busA.ready_po, (e == NUM_A));
    end
    checkOutput("reinit R5", busA.reg1_data_po, 0);
    checkOutput("reinit R3", busA.reg2_data_po, 0);

    // Randomized traffic against the model, with occasional resets
    for (int c = 0; c < 400; c++) begin
      rstA = ($urandom_range(0, 59) != 0);
      busA.wr_en_pi      = 1'($urandom_range(0, 1));
      busA.wr_reg_pi     = 3'($urandom);
      busA.wr_data_pi    = 16'($urandom);
      busA.carry_we_pi   = 1'($urandom_range(0, 1));
      busA.new_carry_pi  = 1'($urandom_range(0, 1));
      busA.borrow_we_pi  = 1'($urandom_range(0, 1));
      busA.new_borrow_pi = 1'($urandom_range(0, 1));
      busA.source_reg1_pi = ($urandom_range(0, 2) == 0) ? busA.wr_reg_pi : 3'($urandom);
      busA.source_reg2_pi = 3'($urandom);
      #1;
      checkOutput("rand reg1", busA.reg1_data_po, expRead(busA.source_reg1_pi));
      checkOutput("rand reg2", busA.reg2_data_po, expRead(busA.source_reg2_pi));
      checkOutput("rand carry", busA.current_carry_po, expFlag(mCarry, busA.carry_we_pi, busA.new_carry_pi));
      checkOutput("rand borrow", busA.current_borrow_po, expFlag(mBorrow, busA.borrow_we_pi, busA.new_borrow_pi));
      checkOutput("rand ready", busA.ready_po, mReady());
      checkOutput("rand dropped", busA.wr_dropped_po, mDropped);
      tick();
    end
    rstA = 1'b1;
    idleA();

    // Instance B: 6 registers, R0 hard-wired to zero, init value 5A5A
    rstB = 1'b1;
    for (int e = 1; e <= NUM_B; e++) begin
      tick();
      checkOutput($sformatf("B init ready e%0d", e), busB.ready_po, (e == NUM_B));
    end
    for (int i = 0; i < 8; i++) begin
      busB.source_reg1_pi = 3'(i);
      #1;
      checkOutput($sformatf("B init R%0d", i), busB.reg1_data_po,
                  (i == 0 || i >= NUM_B) ? 16'h0000 : INIT_B);
    end
    busB.wr_en_pi = 1'b1; busB.wr_reg_pi = 3'd0; busB.wr_data_pi = 16'h1234;
    tick();
    checkOutput("B drop R0", busB.wr_dropped_po, 1);
    busB.wr_reg_pi = 3'd7; busB.wr_data_pi = 16'h5555;
    tick();
    checkOutput("B drop R7", busB.wr_dropped_po, 1);
    busB.wr_reg_pi = 3'd5; busB.wr_data_pi = 16'h0BAD;
    tick();
    checkOutput("B legal R5 no drop", busB.wr_dropped_po, 0);
    busB.wr_en_pi = 1'b0;
    tick();
    checkOutput("B idle no drop", busB.wr_dropped_po, 0);
    busB.source_reg1_pi = 3'd0; busB.source_reg2_pi = 3'd7;
    #1;
    checkOutput("B read R0", busB.reg1_data_po, 0);
    checkOutput("B read R7", busB.reg2_data_po, 0);
    busB.source_reg1_pi = 3'd5; busB.source_reg2_pi = 3'd4;
    #1;
    checkOutput("B read R5", busB.reg1_data_po, 16'h0BAD);
    checkOutput("B read R4", busB.reg2_data_po, INIT_B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
